// File: rtl/turn_countdown_timer.sv
// Two-player turn clock: synchronized 1 Hz tick, RUN/PAUSED/TIMEOUT control.
// Optional per-move increment is compiled in with `define TURN_INCREMENT_EN.
module turn_countdown_timer #(
    parameter int TIME_WIDTH        = 10,
    parameter int START_SECONDS     = 600,
    parameter int INCREMENT_SECONDS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  slowClock,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  turnSwitch,
    output logic [TIME_WIDTH-1:0] timeLeft0,
    output logic [TIME_WIDTH-1:0] timeLeft1,
    output logic                  activePlayer,
    output logic                  timeout0,
    output logic                  timeout1,
    output logic                  running
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, TIMEOUT} state_t;

    localparam logic [TIME_WIDTH-1:0] START_VAL = TIME_WIDTH'(START_SECONDS);
    localparam logic [TIME_WIDTH:0]   INC_VAL   = (TIME_WIDTH+1)'(INCREMENT_SECONDS);
    localparam logic [TIME_WIDTH-1:0] ONE       = TIME_WIDTH'(1);
    localparam logic [TIME_WIDTH-1:0] ZERO      = '0;
`ifdef TURN_INCREMENT_EN
    localparam bit INC_ON = 1'b1;
`else
    localparam bit INC_ON = 1'b0;
`endif

    logic   sync1, sync2, sync3;
    logic   filled, armed, tick;
    state_t state_q, state_d;
    logic [TIME_WIDTH-1:0] t0_d, t1_d;
    logic                  ap_d, to0_d, to1_d;
    logic [TIME_WIDTH-1:0] cur, dec, bumped;
    logic [TIME_WIDTH:0]   sum;
    logic                  dec_en;

    // Synchronize slowClock; arm only after a real low sample so a level
    // already high out of reset cannot masquerade as a rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            filled <= 1'b0;
            armed  <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync1  <= slowClock;
            sync2  <= sync1;
            sync3  <= sync2;
            filled <= 1'b1;
            armed  <= armed | (filled & ~sync1);
            tick   <= armed & sync2 & ~sync3;
        end
    end

    // State and game registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timeLeft0    <= START_VAL;
            timeLeft1    <= START_VAL;
            activePlayer <= 1'b0;
            timeout0     <= 1'b0;
            timeout1     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeLeft0    <= t0_d;
            timeLeft1    <= t1_d;
            activePlayer <= ap_d;
            timeout0     <= to0_d;
            timeout1     <= to1_d;
        end
    end

    // Next-state: start beats everything; in RUN a tick is applied first,
    // then expiry, pause or a turn switch (with optional bonus) follows.
    always_comb begin
        state_d = state_q;
        t0_d    = timeLeft0;
        t1_d    = timeLeft1;
        ap_d    = activePlayer;
        to0_d   = timeout0;
        to1_d   = timeout1;
        cur     = activePlayer ? timeLeft1 : timeLeft0;
        dec_en  = tick && (cur != ZERO);
        dec     = dec_en ? cur - ONE : cur;
        sum     = {1'b0, dec} + INC_VAL;
        if (!INC_ON)
            bumped = dec;
        else if (sum[TIME_WIDTH])
            bumped = '1;
        else
            bumped = sum[TIME_WIDTH-1:0];

        if (start) begin
            state_d = RUN;
            t0_d    = START_VAL;
            t1_d    = START_VAL;
            ap_d    = 1'b0;
            to0_d   = 1'b0;
            to1_d   = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (activePlayer) t1_d = dec;
                    else              t0_d = dec;
                    if (dec_en && cur == ONE) begin
                        state_d = TIMEOUT;
                        if (activePlayer) to1_d = 1'b1;
                        else              to0_d = 1'b1;
                    end else if (pause) begin
                        state_d = PAUSED;
                    end else if (turnSwitch) begin
                        if (activePlayer) t1_d = bumped;
                        else              t0_d = bumped;
                        ap_d = ~activePlayer;
                    end
                end
                PAUSED: begin
                    if (pause) state_d = RUN;
                end
                IDLE, TIMEOUT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign running = (state_q == RUN);

endmodule

// File: tb/tb_turn_countdown_timer.sv
// Directed bench for turn_countdown_timer: three instances with
// START_SECONDS of 600, 2 and 12 driven by independent pulses.
module tb_turn_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] slow  = '0;
    logic [2:0] st    = '0;
    logic [2:0] ps    = '0;
    logic [2:0] sw    = '0;
    logic [9:0] tl0 [3];
    logic [9:0] tl1 [3];
    logic [2:0] ap, to0, to1, run;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    turn_countdown_timer dut0 (
        .clock(clock), .reset(reset), .slowClock(slow[0]),
        .start(st[0]), .pause(ps[0]), .turnSwitch(sw[0]),
        .timeLeft0(tl0[0]), .timeLeft1(tl1[0]), .activePlayer(ap[0]),
        .timeout0(to0[0]), .timeout1(to1[0]), .running(run[0])
    );

    turn_countdown_timer #(.START_SECONDS(2)) dut1 (
        .clock(clock), .reset(reset), .slowClock(slow[1]),
        .start(st[1]), .pause(ps[1]), .turnSwitch(sw[1]),
        .timeLeft0(tl0[1]), .timeLeft1(tl1[1]), .activePlayer(ap[1]),
        .timeout0(to0[1]), .timeout1(to1[1]), .running(run[1])
    );

    turn_countdown_timer #(.START_SECONDS(12)) dut2 (
        .clock(clock), .reset(reset), .slowClock(slow[2]),
        .start(st[2]), .pause(ps[2]), .turnSwitch(sw[2]),
        .timeLeft0(tl0[2]), .timeLeft1(tl1[2]), .activePlayer(ap[2]),
        .timeout0(to0[2]), .timeout1(to1[2]), .running(run[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        assert (got === exp)
        else begin
            nerr++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int i);
        st[i] = 1'b1;
        cyc();
        st[i] = 1'b0;
    endtask

    task automatic pulse_pause(input int i);
        ps[i] = 1'b1;
        cyc();
        ps[i] = 1'b0;
    endtask

    task automatic pulse_switch(input int i);
        sw[i] = 1'b1;
        cyc();
        sw[i] = 1'b0;
    endtask

    // One slowClock period; the decrement lands on the 4th edge.
    task automatic slow_edge(input int i);
        slow[i] = 1'b1;
        repeat (4) cyc();
        slow[i] = 1'b0;
        repeat (3) cyc();
    endtask

    // slowClock rise with turnSwitch timed onto the tick cycle.
    task automatic edge_with_switch(input int i);
        slow[i] = 1'b1;
        repeat (3) cyc();
        sw[i] = 1'b1;
        cyc();
        sw[i] = 1'b0;
        slow[i] = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int exp_inc;

        // Reset state
        repeat (2) cyc();
        check("rst_tl0", tl0[0], 600);
        check("rst_tl1", tl1[0], 600);
        check("rst_ap", ap[0], 0);
        check("rst_to0", to0[0], 0);
        check("rst_run", run[0], 0);
        reset = 1'b0;
        repeat (3) cyc();
        check("idle_run", run[0], 0);

        // Start and decrement latency
        pulse_start(0);
        check("start_run", run[0], 1);
        slow[0] = 1'b1;
        repeat (3) cyc();
        check("lat_before", tl0[0], 600);
        cyc();
        check("lat_after", tl0[0], 599);
        slow[0] = 1'b0;
        repeat (3) cyc();
        slow_edge(0);
        slow_edge(0);
        check("3edge_tl0", tl0[0], 597);
        check("3edge_tl1", tl1[0], 600);
        check("3edge_run", run[0], 1);

        // Pause holds the count
        pulse_pause(0);
        check("paused_run", run[0], 0);
        repeat (5) slow_edge(0);
        check("paused_tl0", tl0[0], 597);
        pulse_pause(0);
        check("resume_run", run[0], 1);
        slow_edge(0);
        check("resume_tl0", tl0[0], 596);

        // Plain turn switch
        pulse_switch(0);
        check("sw_ap", ap[0], 1);
        slow_edge(0);
        check("sw_tl1", tl1[0], 599);
`ifdef TURN_INCREMENT_EN
        exp_inc = 601;
`else
        exp_inc = 596;
`endif
        check("sw_tl0", tl0[0], exp_inc);

        // start + pause + switch together: start wins
        st[0] = 1'b1;
        ps[0] = 1'b1;
        sw[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        ps[0] = 1'b0;
        sw[0] = 1'b0;
        check("prio_tl0", tl0[0], 600);
        check("prio_tl1", tl1[0], 600);
        check("prio_ap", ap[0], 0);
        check("prio_run", run[0], 1);

        // Asynchronous reset mid-run, slowClock left high
        slow_edge(0);
        check("pre_rst_tl0", tl0[0], 599);
        slow[0] = 1'b1;
        repeat (3) cyc();
        #3;
        reset = 1'b1;
        #1;
        check("arst_tl0", tl0[0], 600);
        check("arst_run", run[0], 0);
        cyc();
        #2;
        reset = 1'b0;
        repeat (2) cyc();
        pulse_start(0);
        repeat (10) cyc();
        check("high_no_tick", tl0[0], 600);
        slow[0] = 1'b0;
        repeat (3) cyc();
        slow_edge(0);
        check("rearm_tl0", tl0[0], 599);

        // Expiry with START_SECONDS = 2
        pulse_start(1);
        slow_edge(1);
        check("to_tl0_1", tl0[1], 1);
        slow_edge(1);
        check("to_tl0_0", tl0[1], 0);
        check("to_flag0", to0[1], 1);
        check("to_run", run[1], 0);
        slow_edge(1);
        pulse_switch(1);
        check("to_hold_tl0", tl0[1], 0);
        check("to_hold_tl1", tl1[1], 2);
        check("to_hold_ap", ap[1], 0);
        check("to_hold_to1", to1[1], 0);
        pulse_start(1);
        check("restart_tl0", tl0[1], 2);
        check("restart_to0", to0[1], 0);
        check("restart_run", run[1], 1);

        // Tick + switch reaching zero: timeout wins, player kept
        slow_edge(1);
        edge_with_switch(1);
        check("tie_to_tl0", tl0[1], 0);
        check("tie_to_flag", to0[1], 1);
        check("tie_to_ap", ap[1], 0);

        // Tick + switch at 10 seconds
        pulse_start(2);
        slow_edge(2);
        slow_edge(2);
        check("c_tl0_10", tl0[2], 10);
        edge_with_switch(2);
`ifdef TURN_INCREMENT_EN
        exp_inc = 14;
`else
        exp_inc = 9;
`endif
        check("tie_tl0", tl0[2], exp_inc);
        check("tie_ap", ap[2], 1);
        slow_edge(2);
        check("tie_tl1", tl1[2], 11);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/turn_countdown_timer.md
TURN_COUNTDOWN_TIMER -- requirements
Module: turn_countdown_timer

Interface
REQ-001 The block SHALL have parameter TIME_WIDTH, default 10, giving the width in bits of each player's remaining-seconds count.
REQ-002 The block SHALL have parameter START_SECONDS, default 600, the value loaded into both counts on start; it SHALL be less than 2^TIME_WIDTH.
REQ-003 The block SHALL have parameter INCREMENT_SECONDS, default 5, used only when the increment feature is compiled in.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-005 The block SHALL have the port clock, input, 1 bit: the system clock (50 MHz).
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have the port slowClock, input, 1 bit: the 1 Hz divided square wave, asynchronous to clock as far as this block is concerned.
REQ-008 The block SHALL have the port start, input, 1 bit: single-cycle pulse that loads the counts and begins play.
REQ-009 The block SHALL have the port pause, input, 1 bit: single-cycle pulse that toggles between RUN and PAUSED.
REQ-010 The block SHALL have the port turnSwitch, input, 1 bit: single-cycle pulse that ends the active player's move.
REQ-011 The block SHALL have the port timeLeft0, output, TIME_WIDTH bits: player 0's remaining seconds.
REQ-012 The block SHALL have the port timeLeft1, output, TIME_WIDTH bits: player 1's remaining seconds.
REQ-013 The block SHALL have the port activePlayer, output, 1 bit: 0 when player 0 is to move, 1 when player 1 is to move.
REQ-014 The block SHALL have the ports timeout0 and timeout1, output, 1 bit each: the flagged player's clock has expired.
REQ-015 The block SHALL have the port running, output, 1 bit: high only in the RUN state.

Function
REQ-016 The block SHALL pass slowClock through a 2-flop synchronizer and then a rising-edge detector, producing a one-cycle tick.
REQ-017 The tick SHALL be high during the 3rd clock cycle after the first clock edge that samples slowClock high; the decrement SHALL be visible on the output one cycle after that.
REQ-018 The block SHALL implement the states IDLE, RUN, PAUSED and TIMEOUT.
REQ-019 In IDLE or TIMEOUT, start SHALL load START_SECONDS into both counts, clear both timeout flags, set activePlayer to 0 and enter RUN.
REQ-020 In RUN or PAUSED, start SHALL reload the counts in the same way and enter RUN (restart).
REQ-021 In RUN, a tick SHALL decrement the active player's count by 1.
REQ-022 A decrement from 1 to 0 SHALL set that player's timeout flag and enter TIMEOUT; the count SHALL never wrap below 0.
REQ-023 In RUN, turnSwitch SHALL invert activePlayer.
REQ-024 When a tick and turnSwitch occur in the same cycle, the decrement SHALL apply to the player active before the switch; if that decrement reaches 0, TIMEOUT SHALL win and activePlayer SHALL not change.
REQ-025 In RUN, pause SHALL enter PAUSED; in PAUSED, pause SHALL return to RUN.
REQ-026 Ticks and turnSwitch SHALL be ignored in IDLE, PAUSED and TIMEOUT.
REQ-027 Input priority SHALL be start > pause > turnSwitch; a lower-priority pulse in the same cycle SHALL be dropped.
REQ-028 The counts, activePlayer and timeout flags SHALL hold their values in PAUSED and TIMEOUT.

Reset
REQ-029 Reset SHALL force state IDLE, timeLeft0 = timeLeft1 = START_SECONDS, activePlayer = 0, timeout0 = timeout1 = 0, running = 0, and synchronizer and edge flops = 0.
REQ-030 Reset asserted mid-game SHALL take effect immediately, without waiting for a clock edge.
REQ-031 After reset, slowClock already high SHALL NOT produce a tick until a fresh rising edge is seen.

Configuration
REQ-032 With macro TURN_INCREMENT_EN defined, an accepted turnSwitch in RUN SHALL add INCREMENT_SECONDS to the outgoing player's count, saturating at 2^TIME_WIDTH-1.
REQ-033 When a tick coincides with turnSwitch under TURN_INCREMENT_EN, the outgoing count SHALL become old-1+INCREMENT_SECONDS (saturated); no increment SHALL apply if that decrement reaches 0.
REQ-034 Without TURN_INCREMENT_EN, the increment logic and INCREMENT_SECONDS SHALL have no effect, and turnSwitch SHALL only invert activePlayer.

Verification
REQ-035 Reset, start, then 3 slowClock rising edges -> timeLeft0 = 597, timeLeft1 = 600, running = 1, each decrement visible 4 cycles after the slowClock rise.
REQ-036 START_SECONDS = 2: start, then 2 edges -> timeLeft0 = 0, timeout0 = 1, TIMEOUT; further edges and turnSwitch leave all outputs unchanged.
REQ-037 Pause, 5 edges, pause, 1 edge -> count drops by exactly 1; running is 0 while paused.
REQ-038 turnSwitch coincident with tick at timeLeft0 = 10 -> timeLeft0 = 9, activePlayer = 1; with TURN_INCREMENT_EN -> timeLeft0 = 14.
REQ-039 Reset asserted between clock edges mid-RUN -> outputs return to their reset values asynchronously; slowClock held high afterwards produces no tick.
REQ-040 start, pause and turnSwitch in the same cycle while in RUN -> reload to START_SECONDS, activePlayer = 0, RUN.
